secure_mem_port: RTL
====================

// Module: secure_mem_port
// PURPOSE
//  Sequential load/store responder between the core LSU and the 1024-word data memory.
//  It checks the access key and applies the codebase secure transform.
//  Stores to the secure region are encoded before reaching memory; loads are decoded before return.
//  A bad-key lockout counter temporarily blocks all secure-region traffic.
// PARAMETERS
//  ADDR_W      10       word address width
//  DATA_W      32       data width
//  SEC_BOUND   128      address is secure when req_addr > SEC_BOUND (strict)
//  MAX_FAILS   3        consecutive bad-key secure requests before lockout
//  LOCK_CYCLES 16       lockout duration in clk cycles
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  req_valid   in   1       request valid
//  req_ready   out  1       request accepted when valid&&ready
//  req_we      in   1       1=store, 0=load
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  store data
//  req_key     in   16      access key
//  rsp_valid   out  1       one-cycle response pulse
//  rsp_rdata   out  DATA_W  load data (0 for stores/errors)
//  rsp_err     out  1       request rejected (bad key or locked)
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid the cycle after mem_en&&!mem_we
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1 and all other outputs 0. fail_cnt=0, lock_cnt=0.
//  FSM IDLE->(accept) CHECK: latch we/addr/wdata/key. req_ready=1 only in IDLE.
//  CHECK:
//    secure && (locked || key!=16'h0032) -> RESP with err=1, no mem_en.
//      Increment fail_cnt; reaching MAX_FAILS loads lock_cnt=LOCK_CYCLES and clears fail_cnt.
//    non-secure, or secure with good key -> ACCESS. Good secure key clears fail_cnt.
//    Non-secure requests ignore the key and the lock entirely.
//  ACCESS: mem_en=1 for exactly 1 cycle.
//    Store -> RESP.
//    Load -> RDWAIT.
//  RDWAIT: capture mem_rdata, decode if secure -> RESP.
//  RESP: rsp_valid=1 for 1 cycle -> IDLE.
//  Latency: store 3 cycles accept-to-rsp, load 4 cycles, error 2 cycles.
//  Encode (store, secure): mem_wdata = ((wdata + 15) & 127) / 3 (unsigned, 32-bit wrap).
//  Decode (load, secure): rdata = ((mem_rdata * 3) & 127) - 15 (32-bit wrap; may underflow to 0xFFFF_FFxx).
//  Non-secure: pass-through both directions. req_addr==SEC_BOUND is non-secure.
//  lock_cnt decrements every cycle while >0, independent of FSM; locked = (lock_cnt!=0).
//  A request arriving on the cycle lock_cnt reaches 0 is evaluated with the lock already clear.
//  Reset mid-operation: FSM aborts and no rsp_valid is issued. mem_en drops asynchronously.
// CONFIGURATION
//  SECURE_PORT_AUDIT_EN defined: adds output viol_cnt[15:0].
//    It counts every err response, saturates at 16'hFFFF, and resets to 0.
//  Not defined: port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  secure_pkg holds:
//    SEC_KEY=16'h0032
//    state enum {IDLE,CHECK,ACCESS,RDWAIT,RESP}
//    sec_encode/sec_decode functions
//  Sub-module: secure_xform. It is combinational encode/decode, selected by dir, and reused by other secure ports.
// TESTING
//  Store addr=200 wdata=0x10 key=0x0032 -> mem_we=1, mem_wdata=0x0000000A, rsp_err=0 on cycle 3.
//  Load addr=200 key=0x0032, mem_rdata=0xA -> rsp_rdata=0x0000000F, rsp_valid on cycle 4.
//  Load addr=128 key=0x0000, mem_rdata=0x1234 -> rsp_rdata=0x1234, no error (boundary pass-through).
//  3 stores addr=300 key=0x0031 -> 3 err rsps, no mem_en.
//    Then good-key store within 16 cycles -> err; the same store after 16 cycles succeeds.
//  Load mem_rdata=0x0 at addr=500 -> rsp_rdata=0xFFFFFFF1 (underflow wrap).
//  Assert rst during RDWAIT -> no rsp_valid, outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/secure_pkg.sv
// Shared definitions for secure memory ports: access key, FSM states and the
// secure data transform used on the protected address region.
package secure_pkg;

  localparam logic [15:0] SEC_KEY = 16'h0032;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ACCESS = 3'd2,
    RDWAIT = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Deliberately lossy scramble; all arithmetic wraps at 32 bits.
  function automatic logic [31:0] sec_encode(input logic [31:0] d);
    return ((d + 32'd15) & 32'd127) / 32'd3;
  endfunction

  function automatic logic [31:0] sec_decode(input logic [31:0] d);
    return ((d * 32'd3) & 32'd127) - 32'd15;
  endfunction

endpackage

// File: rtl/secure_xform.sv
// Combinational secure transform: i_dir=0 encodes (store path), i_dir=1 decodes (load path).
module secure_xform
  import secure_pkg::*;
(
  input  logic        i_dir,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  assign o_data = i_dir ? sec_decode(i_data) : sec_encode(i_data);

endmodule

// File: rtl/secure_mem_port.sv
// Sequential load/store responder with key check, bad-key lockout and secure transform.
// Optional build macro SECURE_PORT_AUDIT_EN adds the viol_cnt error counter output.
module secure_mem_port
  import secure_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int SEC_BOUND   = 128,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  // A request transfers on a rising edge where req_valid && req_ready; only one
  // request is outstanding, and each produces exactly one rsp_valid pulse.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [15:0]       req_key,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef SECURE_PORT_AUDIT_EN
  output logic [15:0]       viol_cnt,
`endif
  output logic [2:0]        dbg_state
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_t              r_state, w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [15:0]         r_key;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;

  logic                w_secure, w_locked, w_reject, w_lock_load;
  logic                w_x_dir;
  logic [DATA_W-1:0]   w_x_in, w_x_out;

  assign w_secure    = r_addr > ADDR_W'(SEC_BOUND);
  assign w_locked    = r_lock_cnt != '0;
  assign w_reject    = w_secure && (w_locked || r_key != SEC_KEY);
  assign w_lock_load = (r_state == CHECK) && w_reject &&
                       (r_fail_cnt == FAIL_W'(MAX_FAILS - 1));

  assign w_x_dir = (r_state == RDWAIT);
  assign w_x_in  = w_x_dir ? mem_rdata : r_wdata;

  secure_xform u_xform (
    .i_dir  (w_x_dir),
    .i_data (w_x_in),
    .o_data (w_x_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = CHECK;
      CHECK:   w_next = w_reject ? RESP : ACCESS;
      ACCESS:  w_next = r_we ? RESP : RDWAIT;
      RDWAIT:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_key      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_key   <= req_key;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        CHECK: begin
          if (w_reject) begin
            r_err      <= 1'b1;
            r_fail_cnt <= w_lock_load ? '0 : r_fail_cnt + 1'b1;
          end else if (w_secure) begin
            r_fail_cnt <= '0;
          end
        end
        RDWAIT:  r_rdata <= w_secure ? w_x_out : mem_rdata;
        default: ;
      endcase
    end
  end

  // Lockout timer runs freely; a reload while counting restarts the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_lock_cnt <= '0;
    else if (w_lock_load) r_lock_cnt <= LOCK_W'(LOCK_CYCLES);
    else if (w_locked)    r_lock_cnt <= r_lock_cnt - 1'b1;
  end

`ifdef SECURE_PORT_AUDIT_EN
  logic [15:0] r_viol_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 r_viol_cnt <= '0;
    else if (r_state == CHECK && w_reject && r_viol_cnt != 16'hFFFF) r_viol_cnt <= r_viol_cnt + 16'd1;
  end
  assign viol_cnt = r_viol_cnt;
`endif

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid & r_err;
  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = mem_we ? (w_secure ? w_x_out : r_wdata) : '0;
  assign dbg_state = r_state;

endmodule
